// File: rtl/capture_logger.sv
// capture_logger
//   Multi-channel sample logger backed by a single-port block RAM.
//   A capture (RUN) stores packed channel samples, optionally decimated,
//   until the RAM is full or the host stops it early. The capture is then
//   held frozen (FULL) and can be read back at random addresses (READ) as
//   zero-extended 32-bit words with a one-cycle registered latency.
//
// Optional build macro:
//   LOG_WRAP_EN - circular capture. The write pointer wraps instead of
//                 ending the capture, only a stop request ends it, and
//                 readback address 0 maps to the oldest stored sample.
//
// Ports:
//   clk                  clock
//   i_rst                synchronous, active-high reset
//   i_sample             packed samples, channel 0 in the MSBs
//   i_sample_valid       i_sample is valid this cycle
//   i_decim              keep 1 of every (i_decim+1) valid samples
//   i_run_log            start or restart a capture
//   i_stop_log           end the capture early
//   i_read_log           enter readback
//   i_addr_log_to_mem    readback address
//   o_busy               capture in progress
//   o_mem_full           capture frozen (or wrapped, in circular builds)
//   o_wr_count           number of words written by the last capture
//   o_data_log_from_mem  readback data, zero-extended to 32 bits
//   o_data_valid         readback data is valid
module capture_logger #(
  parameter int ADDR_WIDTH  = 15,
  parameter int CH_WIDTH    = 8,
  parameter int N_CH        = 2,
  parameter int DECIM_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic [N_CH*CH_WIDTH-1:0] i_sample,
  input  logic                     i_sample_valid,
  input  logic [DECIM_WIDTH-1:0]   i_decim,
  input  logic                     i_run_log,
  input  logic                     i_stop_log,
  input  logic                     i_read_log,
  input  logic [ADDR_WIDTH-1:0]    i_addr_log_to_mem,
  output logic                     o_busy,
  output logic                     o_mem_full,
  output logic [ADDR_WIDTH:0]      o_wr_count,
  output logic [31:0]              o_data_log_from_mem,
  output logic                     o_data_valid
);

  localparam int W     = N_CH * CH_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FULL, S_READ} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [DECIM_WIDTH-1:0]  decim_cnt;
  logic [DECIM_WIDTH-1:0]  decim_lat;
  logic                    write_en;
  logic                    run_start;
  logic                    rd_in_range;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [W-1:0]            rd_word;
  logic [31:0]             rd_ext;
  logic [W-1:0]            mem [DEPTH];
`ifdef LOG_WRAP_EN
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  logic                    wrapped;
`endif

  // Write qualification and next-state selection. The stop request
  // outranks run, which outranks read, in every state; a stop outside RUN
  // simply holds the current state.
  always_comb begin
    write_en   = (state == S_RUN) && i_sample_valid && (decim_cnt == '0);
    state_next = state;
    case (state)
      S_IDLE: if (!i_stop_log && i_run_log) state_next = S_RUN;
      S_RUN: begin
        if (i_stop_log) begin
          state_next = S_FULL;
        end
`ifndef LOG_WRAP_EN
        else if (write_en && wr_ptr == LAST_ADDR) begin
          state_next = S_FULL;
        end
`endif
      end
      S_FULL: begin
        if (!i_stop_log) begin
          if (i_run_log)       state_next = S_RUN;
          else if (i_read_log) state_next = S_READ;
        end
      end
      S_READ: if (!i_stop_log && i_run_log) state_next = S_RUN;
      default: state_next = S_IDLE;
    endcase
    run_start = (state != S_RUN) && (state_next == S_RUN);
  end

  // After a wrap, wr_ptr points at the oldest sample, so readback is
  // rotated by it to present the capture in chronological order.
  always_comb begin
`ifdef LOG_WRAP_EN
    rd_addr = wrapped ? (i_addr_log_to_mem + wr_ptr) : i_addr_log_to_mem;
`else
    rd_addr = i_addr_log_to_mem;
`endif
  end

  // Control state, capture pointers and readback qualifiers.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      decim_cnt    <= '0;
      decim_lat    <= '0;
      o_wr_count   <= '0;
      o_data_valid <= 1'b0;
      rd_in_range  <= 1'b0;
`ifdef LOG_WRAP_EN
      wrapped      <= 1'b0;
`endif
    end else begin
      state        <= state_next;
      o_data_valid <= (state == S_READ) && (state_next == S_READ);
      rd_in_range  <= ({1'b0, i_addr_log_to_mem} < o_wr_count);
      if (run_start) begin
        wr_ptr     <= '0;
        decim_cnt  <= '0;
        o_wr_count <= '0;
        decim_lat  <= i_decim;
`ifdef LOG_WRAP_EN
        wrapped    <= 1'b0;
`endif
      end else if (state == S_RUN) begin
        if (i_sample_valid) begin
          decim_cnt <= (decim_cnt == decim_lat) ? '0 : decim_cnt + 1'b1;
        end
        if (write_en) begin
          wr_ptr <= wr_ptr + 1'b1;
`ifdef LOG_WRAP_EN
          if (o_wr_count != FULL_COUNT) o_wr_count <= o_wr_count + 1'b1;
          if (wr_ptr == LAST_ADDR) wrapped <= 1'b1;
`else
          o_wr_count <= o_wr_count + 1'b1;
`endif
        end
      end
    end
  end

  // Block RAM port: write during capture, otherwise a registered read.
  always_ff @(posedge clk) begin
    if (write_en && !i_rst) begin
      mem[wr_ptr] <= i_sample;
    end
    rd_word <= mem[rd_addr];
  end

  always_comb begin
    rd_ext         = '0;
    rd_ext[W-1:0]  = rd_word;
  end

  // Addresses past the last written word read back as zero.
  assign o_data_log_from_mem = (o_data_valid && rd_in_range) ? rd_ext : 32'h0;
  assign o_busy              = (state == S_RUN);
`ifdef LOG_WRAP_EN
  assign o_mem_full          = wrapped || (state == S_FULL) || (state == S_READ);
`else
  assign o_mem_full          = (state == S_FULL) || (state == S_READ);
`endif

endmodule

// File: tb/tb_capture_logger.sv
// tb_capture_logger
//   Directed bench for capture_logger with a 16-word RAM, two 8-bit
//   channels. Covers reset, linear fill, decimation, early stop, restart,
//   mid-capture reset, randomly gapped valid samples and, when built with
//   LOG_WRAP_EN, circular capture.
module tb_capture_logger;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sample;
  logic        sample_valid;
  logic [7:0]  decim;
  logic        run_log;
  logic        stop_log;
  logic        read_log;
  logic [3:0]  addr;
  logic        busy;
  logic        mem_full;
  logic [4:0]  wr_count;
  logic [31:0] data;
  logic        data_valid;

  int          checks = 0;
  int          errors = 0;
  logic        gap_valid;
  logic [15:0] model [$];

  capture_logger #(
    .ADDR_WIDTH (4),
    .CH_WIDTH   (8),
    .N_CH       (2),
    .DECIM_WIDTH(8)
  ) dut (
    .clk                (clk),
    .i_rst              (rst),
    .i_sample           (sample),
    .i_sample_valid     (sample_valid),
    .i_decim            (decim),
    .i_run_log          (run_log),
    .i_stop_log         (stop_log),
    .i_read_log         (read_log),
    .i_addr_log_to_mem  (addr),
    .o_busy             (busy),
    .o_mem_full         (mem_full),
    .o_wr_count         (wr_count),
    .o_data_log_from_mem(data),
    .o_data_valid       (data_valid)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] s, input logic v,
                               input logic run, input logic stop,
                               input logic read, input logic [3:0] a);
    sample       = s;
    sample_valid = v;
    run_log      = run;
    stop_log     = stop;
    read_log     = read;
    addr         = a;
    step();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Must already be in READ: presents an address, then checks the word
  // returned on the following edge.
  task automatic readWord(input logic [3:0] a, input logic [31:0] expected);
    applyStimulus(16'h0, 1'b0, 1'b0, 1'b0, 1'b0, a);
    checkOutput($sformatf("data addr %0d", a), data, expected);
    checkOutput($sformatf("valid addr %0d", a), {31'b0, data_valid}, 32'h1);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " busy"},     {31'b0, busy},       32'h0);
    checkOutput({tag, " mem_full"}, {31'b0, mem_full},   32'h0);
    checkOutput({tag, " wr_count"}, {27'b0, wr_count},   32'h0);
    checkOutput({tag, " data"},     data,                32'h0);
    checkOutput({tag, " valid"},    {31'b0, data_valid}, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    decim = 8'd0;
    sample = '0; sample_valid = 0; run_log = 0; stop_log = 0; read_log = 0; addr = '0;
    step();
    step();
    checkIdleOutputs("reset");
    rst = 1'b0;

`ifndef LOG_WRAP_EN
    $display("[TB] basic fill");
    applyStimulus(16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("fill busy at start", {31'b0, busy}, 32'h1);
    for (int n = 0; n < 16; n++) begin
      applyStimulus(16'h0100 + 16'(n), 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      if (n == 14) begin
        checkOutput("fill busy before last", {31'b0, busy}, 32'h1);
        checkOutput("fill count before last", {27'b0, wr_count}, 32'd15);
      end
    end
    checkOutput("fill busy after last", {31'b0, busy}, 32'h0);
    checkOutput("fill mem_full", {31'b0, mem_full}, 32'h1);
    checkOutput("fill wr_count", {27'b0, wr_count}, 32'd16);
    applyStimulus(16'hDEAD, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    checkOutput("no write in FULL", {27'b0, wr_count}, 32'd16);
    applyStimulus(16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    checkOutput("read entry valid", {31'b0, data_valid}, 32'h0);
    checkOutput("read entry mem_full", {31'b0, mem_full}, 32'h1);
    readWord(4'd5, 32'h00000105);
    readWord(4'd0, 32'h00000100);
    readWord(4'd15, 32'h0000010F);

    $display("[TB] decimation");
    decim = 8'd2;
    applyStimulus(16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("restart busy", {31'b0, busy}, 32'h1);
    checkOutput("restart valid", {31'b0, data_valid}, 32'h0);
    checkOutput("restart wr_count", {27'b0, wr_count}, 32'h0);
    for (int k = 0; k < 96; k++) begin
      if (k % 2 == 0) applyStimulus(16'(k / 2), 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      else            applyStimulus(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      if (k == 89) begin
        checkOutput("decim busy before 16th", {31'b0, busy}, 32'h1);
        checkOutput("decim count before 16th", {27'b0, wr_count}, 32'd15);
      end
    end
    checkOutput("decim mem_full", {31'b0, mem_full}, 32'h1);
    checkOutput("decim wr_count", {27'b0, wr_count}, 32'd16);
    applyStimulus(16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    readWord(4'd0, 32'd0);
    readWord(4'd1, 32'd3);
    readWord(4'd7, 32'd21);
    readWord(4'd15, 32'd45);
`else
    // Enter READ with an empty capture so the later tests start from READ.
    applyStimulus(16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    applyStimulus(16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    readWord(4'd3, 32'h0);
`endif

    $display("[TB] early stop");
    decim = 8'd0;
    applyStimulus(16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("run from read valid", {31'b0, data_valid}, 32'h0);
    checkOutput("run from read wr_count", {27'b0, wr_count}, 32'h0);
    for (int n = 0; n < 7; n++) begin
      applyStimulus(16'h0200 + 16'(n), 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    end
    applyStimulus(16'h0207, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    checkOutput("stop busy", {31'b0, busy}, 32'h0);
    checkOutput("stop mem_full", {31'b0, mem_full}, 32'h1);
    checkOutput("stop wr_count", {27'b0, wr_count}, 32'd8);
    applyStimulus(16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    readWord(4'd7, 32'h00000207);
    readWord(4'd6, 32'h00000206);
    readWord(4'd8, 32'h0);
    readWord(4'd9, 32'h0);

    $display("[TB] mid-capture reset");
    applyStimulus(16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int n = 0; n < 4; n++) begin
      applyStimulus(16'h0300 + 16'(n), 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    end
    rst = 1'b1;
    applyStimulus(16'h03FF, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    checkIdleOutputs("mid reset");
    rst = 1'b0;
    applyStimulus(16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(16'h0400, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    applyStimulus(16'h0401, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    applyStimulus(16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    checkOutput("recapture wr_count", {27'b0, wr_count}, 32'd2);
    applyStimulus(16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    readWord(4'd0, 32'h00000400);
    readWord(4'd1, 32'h00000401);
    readWord(4'd2, 32'h0);

    $display("[TB] valid gaps");
    applyStimulus(16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int c = 0; c < 14; c++) begin
      if (c == 0)      gap_valid = 1'b1;
      else if (c == 1) gap_valid = 1'b0;
      else             gap_valid = 1'($urandom_range(0, 1));
      if (gap_valid) model.push_back(16'h5000 + 16'(c));
      applyStimulus(16'h5000 + 16'(c), gap_valid, 1'b0, 1'b0, 1'b0, 4'd0);
    end
    applyStimulus(16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    checkOutput("gaps wr_count", {27'b0, wr_count}, 32'(model.size()));
    applyStimulus(16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    for (int i = 0; i < model.size(); i++) begin
      readWord(4'(i), {16'h0, model[i]});
    end
    readWord(4'(model.size()), 32'h0);

`ifdef LOG_WRAP_EN
    $display("[TB] circular capture");
    applyStimulus(16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int n = 0; n < 20; n++) begin
      applyStimulus(16'h0600 + 16'(n), 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      if (n == 15) begin
        checkOutput("wrap busy after 16", {31'b0, busy}, 32'h1);
        checkOutput("wrap mem_full after 16", {31'b0, mem_full}, 32'h1);
      end
    end
    checkOutput("wrap count saturates", {27'b0, wr_count}, 32'd16);
    applyStimulus(16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    checkOutput("wrap stop mem_full", {31'b0, mem_full}, 32'h1);
    checkOutput("wrap stop wr_count", {27'b0, wr_count}, 32'd16);
    applyStimulus(16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    readWord(4'd0, 32'h00000604);
    readWord(4'd1, 32'h00000605);
    readWord(4'd15, 32'h00000613);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/capture_logger.md
Name: capture_logger

Overview:
- Parametrised multi-channel sample logger with an internal single-port BRAM.
- Captures packed channel samples from the filter path into BRAM, with optional decimation and early stop.
- Holds the capture frozen, then serves random-access readback to the host interface as 32-bit words.
- Next-generation capture block: configurable channel count and width, sample-valid qualification, registered readback with valid strobe, fill count.

Parameters:
- ADDR_WIDTH, 15: BRAM address width; DEPTH = 2**ADDR_WIDTH words.
- CH_WIDTH, 8: bits per channel sample.
- N_CH, 2: channels packed per word; word width W = N_CH*CH_WIDTH; W must be ≤ 32.
- DECIM_WIDTH, 8: width of the decimation-factor input.

Ports:
- clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_sample  in  N_CH*CH_WIDTH  packed samples; channel 0 in the MSBs, channel N_CH-1 in the LSBs.
- i_sample_valid  in  1  i_sample is valid this cycle.
- i_decim  in  DECIM_WIDTH  keep 1 of every (i_decim+1) valid samples; sampled when RUN is entered.
- i_run_log  in  1  start or restart a capture (level, checked per cycle).
- i_stop_log  in  1  end the capture early.
- i_read_log  in  1  enter readback.
- i_addr_log_to_mem  in  ADDR_WIDTH  read address.
- o_busy  out  1  high in RUN.
- o_mem_full  out  1  high in FULL and READ.
- o_wr_count  out  ADDR_WIDTH+1  number of words written in the last capture.
- o_data_log_from_mem  out  32  read data, zero-extended from W bits.
- o_data_valid  out  1  o_data_log_from_mem holds valid data.

Behaviour:
- Reset (i_rst=1 at a clk edge):
  - State goes to IDLE; all outputs go to 0.
  - Write pointer, decimation counter and o_wr_count are cleared.
  - BRAM contents are not cleared.
  - Reset mid-capture or mid-read behaves the same way; it takes effect at the next edge.
- States are IDLE, RUN, FULL, READ. Priority within a cycle: i_rst > i_stop_log > i_run_log > i_read_log.
- IDLE:
  - i_run_log → RUN.
  - On entry to RUN: wr_ptr=0, decim_cnt=0, o_wr_count=0, latch i_decim.
- RUN:
  - A write occurs when i_sample_valid=1 and decim_cnt==0. The word is written at wr_ptr in the same cycle; wr_ptr and o_wr_count then increment.
  - decim_cnt advances on every valid sample and wraps from latched_decim to 0. i_decim=0 means every valid sample is written.
  - A write at wr_ptr==DEPTH-1 → FULL next cycle, with o_wr_count=DEPTH.
  - i_stop_log → FULL next cycle. A write in that same cycle still completes and is counted.
  - i_run_log while in RUN is ignored.
- FULL:
  - No writes; BRAM is held in read mode.
  - i_read_log → READ; i_run_log → RUN, which starts a new capture.
- READ:
  - Each cycle, i_addr_log_to_mem is presented to the BRAM.
  - Read latency is 1 cycle: o_data_log_from_mem and o_data_valid=1 appear on the edge after the address is presented.
  - Address ≥ o_wr_count returns 0 with o_data_valid=1.
  - i_run_log → RUN; o_data_valid drops to 0 on the next edge.
- o_data_valid is 0 in every state except the cycle following a READ cycle.
- Without the optional feature, o_mem_full = (state==FULL || state==READ).

Optional Feature:
- Macro name: LOG_WRAP_EN.
- Defined (circular capture):
  - In RUN, a write at DEPTH-1 wraps wr_ptr to 0 and does not leave RUN.
  - Only i_stop_log ends the capture.
  - A sticky wrapped flag sets on the first wrap; o_wr_count saturates at DEPTH.
  - In READ with the wrapped flag set, the physical address is (i_addr_log_to_mem + wr_ptr) mod DEPTH, so address 0 is the oldest sample.
  - o_mem_full = wrapped flag, or state in FULL/READ.
- Not defined: linear capture exactly as in Behaviour; no wrapped flag and no address offset logic.

Test Plan (ADDR_WIDTH=4, N_CH=2, CH_WIDTH=8, DEPTH=16):
- Basic fill:
  - Stimulus: reset, i_decim=0, pulse i_run_log, drive i_sample=16'h0100+n with valid=1 every cycle.
  - Required: o_busy high for 16 writes; then o_mem_full=1, o_wr_count=16.
  - Required: READ addr 5 → next cycle o_data_log_from_mem=32'h00000105, o_data_valid=1.
- Decimation:
  - Stimulus: i_decim=2, valid every other cycle, samples 0..47.
  - Required: stored words = samples 0,3,6,…,45; FULL after the 16th write.
- Early stop:
  - Stimulus: i_stop_log after 7 writes, with a valid write in the same cycle.
  - Required: o_wr_count=8; READ addr 7 returns the 8th sample; READ addr 9 returns 0 with o_data_valid=1.
- Restart and mid-operation reset:
  - Stimulus: i_run_log during READ.
  - Required: RUN next cycle, o_data_valid=0, o_wr_count=0.
  - Stimulus: i_rst during RUN after 4 writes.
  - Required: IDLE, all outputs 0; a new capture overwrites from address 0.
- LOG_WRAP_EN:
  - Stimulus: write samples 0..19, then i_stop_log.
  - Required: o_mem_full=1, o_wr_count=16.
  - Required: READ addr 0 returns sample 4; READ addr 15 returns sample 19.
- Valid gaps:
  - Stimulus: random i_sample_valid pattern.
  - Required: only valid samples are stored, in order, with no duplicates.
